// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types, constants and helpers for the sequential BCD converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int BCD_DIGIT_W    = 4;
   localparam int ADD3_THRESHOLD = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } bcd_state_t;

   // Width needed for a counter that must reach in_w inclusive.
   function automatic int cnt_width(input int in_w);
      return $clog2(in_w + 1);
   endfunction

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3_cell.sv
// ============================================================================
// Module   : bcd_add3_cell
// Brief    : One double-dabble correction cell: adds 3 to a digit that is >= 5.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_add3_cell
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   localparam logic [BCD_DIGIT_W-1:0] c_THRESH = BCD_DIGIT_W'(ADD3_THRESHOLD);
   localparam logic [BCD_DIGIT_W-1:0] c_ADJUST = BCD_DIGIT_W'(3);

   assign digit_o = (digit_i >= c_THRESH) ? (digit_i + c_ADJUST) : digit_i;

endmodule

`default_nettype wire

// File: rtl/bcd_seq_converter.sv
// ============================================================================
// Module   : bcd_seq_converter
// Brief    : Iterative binary-to-BCD converter (one digit-cell bank, IN_W cycles).
//            Optional macro BCD_BLANK_LEADING_ZERO_EN adds a leading-zero mask.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_seq_converter
   import bcd_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [IN_W-1:0]             bin_in,
   output logic                        busy,
   output logic                        done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
`ifdef BCD_BLANK_LEADING_ZERO_EN
   ,
   output logic [DIGITS-1:0]           blank_mask
`endif
);

   localparam int c_CNT_W  = cnt_width(IN_W);
   localparam int c_WORK_W = BCD_DIGIT_W * DIGITS;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(IN_W - 1);

   // Too few digits would silently overflow the working register.
   if (pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_bad_params
      $error("bcd_seq_converter: 10**DIGITS must exceed 2**IN_W - 1");
   end

   bcd_state_t            state_q, state_d;
   logic [c_CNT_W-1:0]    cnt_q, cnt_d;
   logic [IN_W-1:0]       shift_q, shift_d;
   logic [c_WORK_W-1:0]   work_q, work_d;
   logic [c_WORK_W-1:0]   bcd_q, bcd_d;
   logic                  done_q, done_d;
   logic [c_WORK_W-1:0]   w_work_corr;
   logic                  w_load;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      bcd_add3_cell u_cell (
         .digit_i (work_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (w_work_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign w_load  = start && ((state_q == IDLE) || (state_q == DONE));
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign bcd_out = bcd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CONVERT;
         CONVERT: if (cnt_q == c_LAST) state_d = DONE;
         DONE:    state_d = start ? CONVERT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      work_d  = work_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;
      case (state_q)
         CONVERT: begin
            // Correct first, then shift the binary MSB into the ones digit.
            {work_d, shift_d} = {w_work_corr[c_WORK_W-2:0], shift_q, 1'b0};
            cnt_d             = cnt_q + 1'b1;
         end
         DONE: begin
            bcd_d  = work_q;
            done_d = 1'b1;
         end
         default: ;
      endcase
      if (w_load) begin
         shift_d = bin_in;
         work_d  = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
         work_q  <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         work_q  <= work_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
      end
   end

`ifdef BCD_BLANK_LEADING_ZERO_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic [DIGITS-1:0] w_blank;

   // Ones digit is never blanked so zero still displays as "0".
   always_comb begin
      logic zero_above;
      w_blank    = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above && (work_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
         w_blank[i] = zero_above;
      end
   end

   always_comb begin
      blank_d = blank_q;
      if (state_q == DONE) begin
         blank_d = w_blank;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank_mask = blank_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
// ============================================================================
// Module   : tb_bcd_seq_converter
// Brief    : Self-checking bench: vector table, corner sequences, random + sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_seq_converter;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start  = 1'b0;
   logic [7:0]  bin_in = 8'd0;
   logic        busy;
   logic        done;
   logic [11:0] bcd_out;
`ifdef BCD_BLANK_LEADING_ZERO_EN
   logic [2:0]  blank_mask;
`endif

   int checks   = 0;
   int failures = 0;

   always #10 clk = ~clk;

   bcd_seq_converter #(.IN_W(8), .DIGITS(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
`ifdef BCD_BLANK_LEADING_ZERO_EN
      ,
      .blank_mask (blank_mask)
`endif
   );

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] exp;
      logic [2:0]  mask;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Decimal reference model: plain division, no shifting.
   function automatic logic [11:0] ref_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [2:0] ref_mask(input int v);
      logic [2:0] m;
      m[2] = ((v / 100) == 0);
      m[1] = ((v / 100) == 0) && (((v / 10) % 10) == 0);
      m[0] = 1'b0;
      return m;
   endfunction

   // Called with DUT idle; returns #1 after the accepting edge.
   task automatic start_conv(input logic [7:0] v);
      start  = 1'b1;
      bin_in = v;
      @(posedge clk); #1;
      start  = 1'b0;
      bin_in = 8'($urandom);
   endtask

   task automatic wait_done(input string nm, input logic [11:0] exp, input logic [2:0] exp_mask,
                            input logic [11:0] prev, output bit seen);
      int lat;
      int busy_n;
      bit hold_ok;
      lat     = 0;
      hold_ok = 1'b1;
      seen    = 1'b0;
      busy_n  = busy ? 1 : 0;
      while (lat < 30 && !seen) begin
         @(posedge clk); #1;
         lat++;
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_n++;
            if (bcd_out !== prev) hold_ok = 1'b0;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done required=done", nm);
      end else begin
         chk({nm, "_latency"}, lat, 9);
         chk({nm, "_bcd"}, bcd_out, exp);
         chk({nm, "_hold"}, hold_ok, 1);
         chk({nm, "_busy_cycles"}, busy_n, 9);
         chk({nm, "_busy_after"}, busy, 0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
         chk({nm, "_mask"}, blank_mask, exp_mask);
`endif
         @(posedge clk); #1;
         chk({nm, "_done_pulse"}, done, 0);
      end
   endtask

   initial begin
      logic [11:0] last;
      bit          seen;
      int          c;
      int          ndone;
      int          v;

      tbl[0] = '{8'd255, 12'h255, 3'b000};
      tbl[1] = '{8'd0,   12'h000, 3'b110};
      tbl[2] = '{8'd99,  12'h099, 3'b100};
      tbl[3] = '{8'd10,  12'h010, 3'b100};
      tbl[4] = '{8'd200, 12'h200, 3'b000};
      tbl[5] = '{8'd37,  12'h037, 3'b100};
      tbl[6] = '{8'd128, 12'h128, 3'b000};
      tbl[7] = '{8'd9,   12'h009, 3'b110};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_bcd", bcd_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      last = 12'h000;

      for (int i = 0; i < 8; i++) begin
         start_conv(tbl[i].bin);
         wait_done($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].mask, last, seen);
         last = tbl[i].exp;
      end

      // Inputs toggled during CONVERT must not disturb or re-trigger.
      start  = 1'b1;
      bin_in = 8'd99;
      @(posedge clk); #1;
      c = 0;
      while (c < 30 && !done) begin
         if (c < 6) begin
            start  = 1'($urandom);
            bin_in = 8'($urandom);
         end else begin
            start  = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      chk("toggle_latency", c, 9);
      chk("toggle_bcd", bcd_out, 12'h099);
      ndone = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("toggle_no_second_done", ndone, 0);
      last = 12'h099;

      // Back-to-back with start held high.
      start  = 1'b1;
      bin_in = 8'd10;
      @(posedge clk); #1;
      bin_in = 8'd200;
      c = 0;
      while (c < 30 && !done) begin
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      chk("b2b_first_latency", c, 9);
      chk("b2b_first_bcd", bcd_out, 12'h010);
      chk("b2b_busy_stays", busy, 1);
      c = 0;
      do begin
         @(posedge clk); #1;
         c++;
      end while (c < 30 && !done);
      chk("b2b_gap", c, 9);
      chk("b2b_second_bcd", bcd_out, 12'h200);
      @(posedge clk); #1;
      last = 12'h200;

      // Reset in the middle of a conversion.
      start_conv(8'd37);
      wait_done("pre_reset", 12'h037, 3'b100, last, seen);
      start_conv(8'd128);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_bcd", bcd_out, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_conv(8'd128);
      wait_done("post_reset", 12'h128, 3'b000, 12'h000, seen);
      last = 12'h128;

      // Random operands against the decimal model.
      repeat (40) begin
         v = int'($urandom_range(0, 255));
         start_conv(8'(v));
         wait_done($sformatf("rand_%0d", v), ref_bcd(v), ref_mask(v), last, seen);
         last = ref_bcd(v);
      end

      // Exhaustive sweep.
      ndone = 0;
      for (int s = 0; s < 256; s++) begin
         start_conv(8'(s));
         wait_done($sformatf("sweep_%0d", s), ref_bcd(s), ref_mask(s), last, seen);
         if (seen) ndone++;
         last = ref_bcd(s);
      end
      chk("sweep_done_count", ndone, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Reuses one bank of add-3 correction cells over IN_W clock cycles instead of the fully unrolled combinational array.
- The controller sequences the correction/shift datapath and provides a start/busy/done handshake.
- Feeds display and readout logic that needs ONES/TENS/HUNDREDS digits from an 8-bit count.

Parameters:
- IN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits.
  - Constraint: 10^DIGITS > 2^IN_W - 1.
  - Violation is an elaboration-time error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request conversion of bin_in; sampled on the rising edge.
- bin_in  in  IN_W  binary operand; captured only on an accepted start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd_out is updated.
- bcd_out  out  4*DIGITS  result, ones in [3:0], tens in [7:4], hundreds in [11:8].

Behaviour:
- Reset (async assert, sync-to-clk release):
  - state=IDLE.
  - busy=0, done=0, bcd_out=0, iteration counter=0, shift register=0.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - start=1 → capture bin_in into the shift register, clear the BCD working register and counter, go to CONVERT.
  - start=0 → stay in IDLE.
- CONVERT, each cycle:
  - Every working digit >= 5 gets +3 (4-bit, no carry out).
  - Then {bcd_work, bin_shift} shifts left by 1; bin MSB enters ones bit 0.
  - Counter increments. After exactly IN_W CONVERT cycles, go to DONE.
- DONE (one cycle):
  - Register bcd_out from the working register.
  - done=1 for this cycle only.
  - start=1 → capture new operand, go straight to CONVERT (back-to-back, no IDLE bubble).
  - start=0 → go to IDLE.
- busy=1 in CONVERT and DONE, 0 in IDLE.
- Latency: start accepted at edge k → done high in the cycle after edge k+IN_W+1.
  - IN_W=8: done asserts 9 cycles after acceptance.
- bcd_out holds its last result until the next DONE; it never shows intermediate values.
- start in CONVERT is ignored (no queueing). bin_in changes after capture have no effect.
- Counter width is clog2(IN_W+1). Working register is 4*DIGITS bits. No arithmetic overflow is possible given the parameter constraint.
- rst_n asserted mid-conversion aborts immediately to reset values. No done is produced and the previous bcd_out is cleared.

Optional Feature:
- Macro: BCD_BLANK_LEADING_ZERO_EN
- Defined: adds output blank_mask [DIGITS-1:0], registered with bcd_out in DONE.
  - Bit i=1 when digit i and all higher digits are zero.
  - Bit 0 is always 0, so a value of 0 shows a single "0".
  - Reset value is 0.
- Undefined: port absent, no extra logic, all other behaviour identical.

Decomposition:
- Package bcd_pkg holds:
  - state enum bcd_state_t {IDLE, CONVERT, DONE}.
  - localparam BCD_DIGIT_W=4.
  - localparam ADD3_THRESHOLD=5.
  - function for counter width.
- Sub-module bcd_add3_cell: 4-bit combinational correction, out = (in>=5) ? in+3 : in.
  - Instantiated DIGITS times in a generate loop.
- Controller FSM and shift register stay in the top module.

Test Plan:
- Reset then start with bin_in=8'd255 → done after 9 cycles, bcd_out=12'h255, busy high for exactly those cycles.
- bin_in=0 → bcd_out=12'h000. With BCD_BLANK_LEADING_ZERO_EN, blank_mask=3'b110.
- bin_in=99 → bcd_out=12'h099, blank_mask=3'b100. Toggle start and bin_in during CONVERT → result unchanged, no second done.
- start held high continuously with bin_in=10, then 200 → done pulses exactly 9 cycles apart, results 12'h010 then 12'h200.
- Complete bin_in=37 (bcd_out=12'h037), start bin_in=128, assert rst_n=0 at cycle 4 of that conversion → busy, done and bcd_out go to 0 immediately. A new start after release yields 12'h128 in 9 cycles.
- Sweep bin_in 0..255 with clk period 20 ns → every result equals a decimal reference model; done count equals 256.
